// File: rtl/sad_match_sequencer.sv
// Scan sequencer for the SAD template matcher: walks the template over every candidate row window,
// drives the PE array and reports the result over UART. Optional stats counter: SAD_SCAN_STATS_EN.
module sad_match_sequencer #(
  parameter int TPL_W    = 40,
  parameter int TPL_H    = 100,
  parameter int IMG_ROWS = 480,
  parameter int RAM_AW   = 9,
  parameter int ROM_AW   = 12,
  parameter int SAD_W    = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              fifo_ready,
  input  logic              pe_match,
  input  logic [SAD_W-1:0]  pe_sad,
  input  logic              uart_done,
  output logic [RAM_AW-1:0] ram_row,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              pe_shift,
  output logic              pe_clear,
  output logic              busy,
  output logic [1:0]        uart_send,
  output logic [RAM_AW-1:0] result_row,
  output logic [SAD_W-1:0]  result_sad
`ifdef SAD_SCAN_STATS_EN
  ,
  output logic [RAM_AW-1:0] match_count
`endif
);

  localparam int COL_W  = (TPL_W > 1) ? $clog2(TPL_W) : 1;
  localparam int TROW_W = (TPL_H > 1) ? $clog2(TPL_H) : 1;
  localparam logic [RAM_AW-1:0] LAST_CAND = RAM_AW'(IMG_ROWS - TPL_H);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(TPL_W - 1);
  localparam logic [TROW_W-1:0] TROW_LAST = TROW_W'(TPL_H - 1);
  localparam logic [SAD_W-1:0]  SAD_ONES  = {SAD_W{1'b1}};
  localparam logic [1:0] UART_OFF       = 2'd0;
  localparam logic [1:0] UART_MATCH     = 2'd1;
  localparam logic [1:0] UART_NOT_MATCH = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FIFO = 3'd1,
    S_SCAN      = 3'd2,
    S_EVAL      = 3'd3,
    S_REPORT    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [RAM_AW-1:0]   cand_q, cand_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [TROW_W-1:0]   trow_q, trow_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [RAM_AW-1:0]   ram_row_q, ram_row_d;
  logic                pe_shift_q, pe_shift_d;
  logic                pe_clear_q, pe_clear_d;
  logic                busy_q, busy_d;
  logic [1:0]          uart_send_q, uart_send_d;
  logic [RAM_AW-1:0]   result_row_q, result_row_d;
  logic [SAD_W-1:0]    result_sad_q, result_sad_d;
  logic [SAD_W-1:0]    best_sad_q, best_sad_d;
  logic                found_q, found_d;
  logic                cand_ok_q, cand_ok_d;
`ifdef SAD_SCAN_STATS_EN
  logic [RAM_AW-1:0]   match_count_q, match_count_d;
`endif

  logic last_col_s, last_pix_s, cand_end_s, better_s;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    cand_d       = cand_q;
    col_d        = col_q;
    trow_d       = trow_q;
    rom_addr_d   = rom_addr_q;
    pe_shift_d   = 1'b0;
    pe_clear_d   = 1'b0;
    uart_send_d  = UART_OFF;
    result_row_d = result_row_q;
    result_sad_d = result_sad_q;
    best_sad_d   = best_sad_q;
    found_d      = found_q;
    cand_ok_d    = cand_ok_q;
`ifdef SAD_SCAN_STATS_EN
    match_count_d = match_count_q;
`endif

    last_col_s = (col_q == COL_LAST);
    last_pix_s = last_col_s && (trow_q == TROW_LAST);
    cand_end_s = last_pix_s || !pe_match;
    better_s   = cand_ok_q && (pe_sad < best_sad_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_WAIT_FIFO;
          mode_d       = mode;
          cand_d       = '0;
          best_sad_d   = SAD_ONES;
          found_d      = 1'b0;
          result_row_d = '0;
          result_sad_d = '0;
`ifdef SAD_SCAN_STATS_EN
          match_count_d = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_FIFO: begin
        if (fifo_ready) begin
          state_d    = S_SCAN;
          pe_clear_d = 1'b1;
          col_d      = '0;
          trow_d     = '0;
          rom_addr_d = '0;
          cand_ok_d  = 1'b0;
        end else begin
          state_d = S_WAIT_FIFO;
        end
      end
      S_SCAN: begin
        pe_shift_d = last_col_s;
        if (cand_end_s) begin
          state_d   = S_EVAL;
          cand_ok_d = last_pix_s && pe_match;
        end else begin
          rom_addr_d = rom_addr_q + ROM_AW'(1);
          if (last_col_s) begin
            col_d  = '0;
            trow_d = trow_q + TROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_EVAL: begin
`ifdef SAD_SCAN_STATS_EN
        if (cand_ok_q && (match_count_q != {RAM_AW{1'b1}})) begin
          match_count_d = match_count_q + RAM_AW'(1);
        end else begin
          match_count_d = match_count_q;
        end
`endif
        if (!mode_q && cand_ok_q) begin
          state_d      = S_REPORT;
          uart_send_d  = UART_MATCH;
          result_row_d = cand_q;
          result_sad_d = pe_sad;
        end else begin
          // Best-match keeps the earlier row on a tie because the compare is strict.
          if (mode_q && better_s) begin
            best_sad_d   = pe_sad;
            result_row_d = cand_q;
            result_sad_d = pe_sad;
            found_d      = 1'b1;
          end else begin
            best_sad_d = best_sad_q;
          end
          if (cand_q == LAST_CAND) begin
            state_d = S_REPORT;
            if (mode_q && (found_q || better_s)) begin
              uart_send_d = UART_MATCH;
            end else begin
              uart_send_d  = UART_NOT_MATCH;
              result_row_d = '0;
              result_sad_d = SAD_ONES;
            end
          end else begin
            state_d    = S_SCAN;
            cand_d     = cand_q + RAM_AW'(1);
            pe_clear_d = 1'b1;
            col_d      = '0;
            trow_d     = '0;
            rom_addr_d = '0;
            cand_ok_d  = 1'b0;
          end
        end
      end
      S_REPORT: begin
        if (uart_done) begin
          state_d = S_IDLE;
        end else begin
          uart_send_d = uart_send_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ram_row_d = cand_d + RAM_AW'(trow_d);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      cand_q       <= '0;
      col_q        <= '0;
      trow_q       <= '0;
      rom_addr_q   <= '0;
      ram_row_q    <= '0;
      pe_shift_q   <= 1'b0;
      pe_clear_q   <= 1'b0;
      busy_q       <= 1'b0;
      uart_send_q  <= UART_OFF;
      result_row_q <= '0;
      result_sad_q <= '0;
      best_sad_q   <= SAD_ONES;
      found_q      <= 1'b0;
      cand_ok_q    <= 1'b0;
`ifdef SAD_SCAN_STATS_EN
      match_count_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      cand_q       <= cand_d;
      col_q        <= col_d;
      trow_q       <= trow_d;
      rom_addr_q   <= rom_addr_d;
      ram_row_q    <= ram_row_d;
      pe_shift_q   <= pe_shift_d;
      pe_clear_q   <= pe_clear_d;
      busy_q       <= busy_d;
      uart_send_q  <= uart_send_d;
      result_row_q <= result_row_d;
      result_sad_q <= result_sad_d;
      best_sad_q   <= best_sad_d;
      found_q      <= found_d;
      cand_ok_q    <= cand_ok_d;
`ifdef SAD_SCAN_STATS_EN
      match_count_q <= match_count_d;
`endif
    end
  end

  assign ram_row    = ram_row_q;
  assign rom_addr   = rom_addr_q;
  assign pe_shift   = pe_shift_q;
  assign pe_clear   = pe_clear_q;
  assign busy       = busy_q;
  assign uart_send  = uart_send_q;
  assign result_row = result_row_q;
  assign result_sad = result_sad_q;
`ifdef SAD_SCAN_STATS_EN
  assign match_count = match_count_q;
`endif

endmodule

// File: tb/tb_sad_match_sequencer.sv
// Directed bench for sad_match_sequencer with a 4x3 template over an 8-row image (candidates 0..5).
module tb_sad_match_sequencer;

  logic       clock;
  logic       reset;
  logic       start;
  logic       mode;
  logic       fifo_ready;
  logic       pe_match;
  logic [7:0] pe_sad;
  logic       uart_done;
  logic [3:0] ram_row;
  logic [3:0] rom_addr;
  logic       pe_shift;
  logic       pe_clear;
  logic       busy;
  logic [1:0] uart_send;
  logic [3:0] result_row;
  logic [7:0] result_sad;
`ifdef SAD_SCAN_STATS_EN
  logic [3:0] match_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int sh;
  logic [7:0] sads [6];

  sad_match_sequencer #(
    .TPL_W(4), .TPL_H(3), .IMG_ROWS(8), .RAM_AW(4), .ROM_AW(4), .SAD_W(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .fifo_ready (fifo_ready),
    .pe_match   (pe_match),
    .pe_sad     (pe_sad),
    .uart_done  (uart_done),
    .ram_row    (ram_row),
    .rom_addr   (rom_addr),
    .pe_shift   (pe_shift),
    .pe_clear   (pe_clear),
    .busy       (busy),
    .uart_send  (uart_send),
    .result_row (result_row),
    .result_sad (result_sad)
`ifdef SAD_SCAN_STATS_EN
    ,
    .match_count(match_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept a start and step into the first SCAN cycle of candidate 0.
  task automatic begin_scan(input logic m);
    start = 1'b1;
    mode = m;
    fifo_ready = 1'b1;
    tick();
    check("wait_busy", 32'(busy), 32'd1);
    start = 1'b0;
    tick();
  endtask

  // Called in a candidate's first SCAN cycle; returns in the cycle after its EVAL.
  task automatic do_cand(input int c, input logic pass, input logic [7:0] sad);
    check("cand_row", 32'(ram_row), 32'(c));
    check("cand_clear", 32'(pe_clear), 32'd1);
    pe_match = pass;
    pe_sad = sad;
    if (pass) repeat (12) tick();
    else tick();
    check("eval_clear", 32'(pe_clear), 32'd0);
    check("eval_shift", 32'(pe_shift), 32'(pass));
    check("eval_uart", 32'(uart_send), 32'd0);
    tick();
  endtask

  task automatic finish_report();
    uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_uart", 32'(uart_send), 32'd0);
  endtask

  initial begin
    sads = '{8'd9, 8'd4, 8'd6, 8'd4, 8'd8, 8'd5};
    reset = 1'b1; start = 1'b0; mode = 1'b0; fifo_ready = 1'b0;
    pe_match = 1'b1; pe_sad = 8'd0; uart_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_uart", 32'(uart_send), 32'd0);
    check("rst_rom", 32'(rom_addr), 32'd0);
    check("rst_ram", 32'(ram_row), 32'd0);
    check("rst_row", 32'(result_row), 32'd0);
    check("rst_sad", 32'(result_sad), 32'd0);
    check("rst_shift", 32'(pe_shift), 32'd0);

    // Reset in SCAN at the last column, where a shift pulse would otherwise follow.
    pe_sad = 8'd7;
    begin_scan(1'b0);
    repeat (3) tick();
    check("t1_rom3", 32'(rom_addr), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_uart", 32'(uart_send), 32'd0);
    check("t1_shift", 32'(pe_shift), 32'd0);
    check("t1_rom", 32'(rom_addr), 32'd0);

    // Mode 0 full match on candidate 0.
    begin_scan(1'b0);
    sh = 0;
    for (int i = 0; i < 12; i++) begin
      check("t2_rom", 32'(rom_addr), 32'(i));
      check("t2_ram", 32'(ram_row), 32'(i / 4));
      check("t2_clear", 32'(pe_clear), 32'(i == 0));
      sh = sh + int'(pe_shift);
      tick();
    end
    sh = sh + int'(pe_shift);
    check("t2_shift_last", 32'(pe_shift), 32'd1);
    check("t2_eval_uart", 32'(uart_send), 32'd0);
    tick();
    check("t2_shifts", 32'(sh), 32'd3);
    check("t2_uart", 32'(uart_send), 32'd1);
    check("t2_row", 32'(result_row), 32'd0);
    check("t2_sad", 32'(result_sad), 32'd7);
    finish_report();
    check("t2_hold_row", 32'(result_row), 32'd0);
    check("t2_hold_sad", 32'(result_sad), 32'd7);

    // Mode 0, every candidate aborts on its first pixel.
    begin_scan(1'b0);
    for (int c = 0; c < 6; c++) do_cand(c, 1'b0, 8'd0);
    check("t3_uart", 32'(uart_send), 32'd2);
    check("t3_row", 32'(result_row), 32'd0);
    check("t3_sad", 32'(result_sad), 32'd255);
    finish_report();

    // Mode 1, best SAD with a tie resolved to the earlier row.
    begin_scan(1'b1);
    for (int c = 0; c < 6; c++) do_cand(c, 1'b1, sads[c]);
    check("t4_uart", 32'(uart_send), 32'd1);
    check("t4_row", 32'(result_row), 32'd1);
    check("t4_sad", 32'(result_sad), 32'd4);
    finish_report();

    // Start, mode change and uart_done mid-scan are ignored.
    pe_match = 1'b1;
    pe_sad = 8'd3;
    begin_scan(1'b0);
    repeat (2) tick();
    start = 1'b1; mode = 1'b1; uart_done = 1'b1;
    tick();
    start = 1'b0; uart_done = 1'b0;
    check("t5_rom", 32'(rom_addr), 32'd3);
    check("t5_busy", 32'(busy), 32'd1);
    repeat (10) tick();
    check("t5_uart", 32'(uart_send), 32'd1);
    check("t5_row", 32'(result_row), 32'd0);
    check("t5_sad", 32'(result_sad), 32'd3);
    repeat (3) begin
      tick();
      check("t5_uart_hold", 32'(uart_send), 32'd1);
    end
    finish_report();

    // Mode 1 after a delayed fifo_ready; only candidates 2 and 4 pass.
    start = 1'b1; mode = 1'b1; fifo_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    check("t6_wait_busy", 32'(busy), 32'd1);
    check("t6_wait_clear", 32'(pe_clear), 32'd0);
    fifo_ready = 1'b1;
    tick();
    do_cand(0, 1'b0, 8'd1);
    do_cand(1, 1'b0, 8'd1);
    do_cand(2, 1'b1, 8'd6);
    do_cand(3, 1'b0, 8'd1);
    do_cand(4, 1'b1, 8'd3);
    do_cand(5, 1'b0, 8'd1);
    check("t6_uart", 32'(uart_send), 32'd1);
    check("t6_row", 32'(result_row), 32'd4);
    check("t6_sad", 32'(result_sad), 32'd3);
`ifdef SAD_SCAN_STATS_EN
    check("t6_count", 32'(match_count), 32'd2);
`endif
    finish_report();

    // Mode 1 with no passing candidate reports NOT_MATCH.
    begin_scan(1'b1);
    for (int c = 0; c < 6; c++) do_cand(c, 1'b0, 8'd2);
    check("t7_uart", 32'(uart_send), 32'd2);
    check("t7_row", 32'(result_row), 32'd0);
    check("t7_sad", 32'(result_sad), 32'd255);
`ifdef SAD_SCAN_STATS_EN
    check("t7_count", 32'(match_count), 32'd0);
`endif
    finish_report();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
